// File: rtl/ksa_seq_pkg.sv
// Shared constants for ksa_wide_seq: register offsets, CTRL/STATUS bit positions, FSM states.
package ksa_seq_pkg;

   localparam logic [7:0] OFF_CTRL   = 8'h00;
   localparam logic [7:0] OFF_STATUS = 8'h04;
   localparam logic [7:0] OFF_A_LO   = 8'h08;
   localparam logic [7:0] OFF_A_HI   = 8'h0C;
   localparam logic [7:0] OFF_B_LO   = 8'h10;
   localparam logic [7:0] OFF_B_HI   = 8'h14;
   localparam logic [7:0] OFF_R_LO   = 8'h18;
   localparam logic [7:0] OFF_R_HI   = 8'h1C;

   localparam int CTRL_START  = 0;
   localparam int CTRL_NL     = 1;
   localparam int CTRL_SUB    = 3;
   localparam int CTRL_IRQ_EN = 8;

   localparam int ST_BUSY  = 0;
   localparam int ST_DONE  = 1;
   localparam int ST_CARRY = 2;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ADD,
      S_CARRY,
      S_DONE
   } state_t;

   function automatic logic [31:0] be_merge(
      input logic [31:0] old_v,
      input logic [31:0] new_v,
      input logic [3:0]  sel
   );
      logic [31:0] res;
      for (int b = 0; b < 4; b++)
         res[8*b +: 8] = sel[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
      return res;
   endfunction

endpackage

// File: rtl/KSA16.sv
// 16-bit Kogge-Stone adder without carry-in.
module KSA16 (
   input  logic [15:0] a_i,
   input  logic [15:0] b_i,
   output logic [15:0] sum_o,
   output logic        cout_o
);

   function automatic logic [15:0] ks_g(
      input logic [15:0] g,
      input logic [15:0] p,
      input int          d
   );
      logic [15:0] r;
      for (int k = 0; k < 16; k++)
         r[k] = (k >= d) ? (g[k] | (p[k] & g[k-d])) : g[k];
      return r;
   endfunction

   function automatic logic [15:0] ks_p(
      input logic [15:0] p,
      input int          d
   );
      logic [15:0] r;
      for (int k = 0; k < 16; k++)
         r[k] = (k >= d) ? (p[k] & p[k-d]) : p[k];
      return r;
   endfunction

   logic [15:0] g0, g1, g2, g3, g4;
   logic [15:0] p0, p1, p2, p3;

   always_comb begin
      g0 = a_i & b_i;
      p0 = a_i ^ b_i;
      g1 = ks_g(g0, p0, 1);
      p1 = ks_p(p0, 1);
      g2 = ks_g(g1, p1, 2);
      p2 = ks_p(p1, 2);
      g3 = ks_g(g2, p2, 4);
      p3 = ks_p(p2, 4);
      g4 = ks_g(g3, p3, 8);
   end

   assign sum_o  = p0 ^ {g4[14:0], 1'b0};
   assign cout_o = g4[15];

endmodule

// File: rtl/ksa_wide_seq.sv
// Wishbone sequencer running up to 64-bit add/sub limb by limb on one KSA16.
// Optional subtraction is enabled by defining KSA_SEQ_SUB_EN.
module ksa_wide_seq #(
   parameter int          LIMBS     = 4,
   parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_ni,
   input  logic        wbs_stb_i,
   input  logic        wbs_cyc_i,
   input  logic        wbs_we_i,
   input  logic [3:0]  wbs_sel_i,
   input  logic [31:0] wbs_adr_i,
   input  logic [31:0] wbs_dat_i,
   output logic        wbs_ack_o,
   output logic [31:0] wbs_dat_o,
   output logic        irq_o
);
   import ksa_seq_pkg::*;

   localparam int W = 16 * LIMBS;

   state_t        state_q;
   logic [W-1:0]  a_q, b_q, r_q;
   logic [1:0]    nl_q, idx_q;
   logic          sub_q, irq_en_q, done_q, carry_q, c1_q, ack_q;
   logic [15:0]   s1_q;
   logic [31:0]   dat_q;

   logic          hit, ack_d, wr, busy, start, wr_sub;
   logic [7:0]    off;
   logic [31:0]   rdat_d;
   logic [15:0]   add_a, add_b, add_s;
   logic          add_co;

   assign off   = wbs_adr_i[7:0];
   assign hit   = wbs_adr_i[31:8] == BASE_ADDR[31:8];
   assign ack_d = wbs_stb_i & wbs_cyc_i & hit & ~ack_q;
   assign wr    = ack_q & wbs_stb_i & wbs_cyc_i & wbs_we_i;
   assign busy  = (state_q == S_ADD) | (state_q == S_CARRY);
   assign start = wr & (off == OFF_CTRL) & wbs_dat_i[CTRL_START]
                & (state_q == S_IDLE);

`ifdef KSA_SEQ_SUB_EN
   assign wr_sub = wbs_dat_i[CTRL_SUB];
`else
   assign wr_sub = 1'b0;
`endif

   // No carry-in on the adder: operands first, then fold in the carry.
   always_comb begin
      add_a = '0;
      add_b = '0;
      case (state_q)
         S_ADD: begin
            add_a = a_q[{idx_q, 4'b0} +: 16];
            add_b = b_q[{idx_q, 4'b0} +: 16] ^ {16{sub_q}};
         end
         S_CARRY: begin
            add_a = s1_q;
            add_b = {15'b0, carry_q};
         end
         default: ;
      endcase
   end

   KSA16 u_ksa (
      .a_i    (add_a),
      .b_i    (add_b),
      .sum_o  (add_s),
      .cout_o (add_co)
   );

   always_comb begin
      rdat_d = '0;
      case (off)
         OFF_CTRL: begin
            rdat_d[CTRL_NL +: 2]  = nl_q;
            rdat_d[CTRL_SUB]      = sub_q;
            rdat_d[CTRL_IRQ_EN]   = irq_en_q;
         end
         OFF_STATUS: begin
            rdat_d[ST_BUSY]  = busy;
            rdat_d[ST_DONE]  = done_q;
            rdat_d[ST_CARRY] = carry_q;
         end
         OFF_A_LO: rdat_d = a_q[31:0];
         OFF_A_HI: rdat_d = a_q[63:32];
         OFF_B_LO: rdat_d = b_q[31:0];
         OFF_B_HI: rdat_d = b_q[63:32];
         OFF_R_LO: rdat_d = r_q[31:0];
         OFF_R_HI: rdat_d = r_q[63:32];
         default: ;
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_ni) begin
         state_q  <= S_IDLE;
         a_q      <= '0;
         b_q      <= '0;
         r_q      <= '0;
         nl_q     <= '0;
         idx_q    <= '0;
         sub_q    <= 1'b0;
         irq_en_q <= 1'b0;
         done_q   <= 1'b0;
         carry_q  <= 1'b0;
         c1_q     <= 1'b0;
         s1_q     <= '0;
         ack_q    <= 1'b0;
         dat_q    <= '0;
      end else begin
         ack_q <= ack_d;
         dat_q <= (ack_d & ~wbs_we_i) ? rdat_d : '0;
         if (wr && !busy) begin
            case (off)
               OFF_CTRL: begin
                  nl_q     <= wbs_dat_i[CTRL_NL +: 2];
                  sub_q    <= wr_sub;
                  irq_en_q <= wbs_dat_i[CTRL_IRQ_EN];
               end
               OFF_A_LO: a_q[31:0]  <= be_merge(a_q[31:0], wbs_dat_i, wbs_sel_i);
               OFF_A_HI: a_q[63:32] <= be_merge(a_q[63:32], wbs_dat_i, wbs_sel_i);
               OFF_B_LO: b_q[31:0]  <= be_merge(b_q[31:0], wbs_dat_i, wbs_sel_i);
               OFF_B_HI: b_q[63:32] <= be_merge(b_q[63:32], wbs_dat_i, wbs_sel_i);
               default: ;
            endcase
         end
         // Clear first so a same-cycle completion below wins.
         if (wr && (off == OFF_STATUS) && wbs_dat_i[ST_DONE])
            done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_q <= S_ADD;
                  idx_q   <= '0;
                  done_q  <= 1'b0;
                  r_q     <= '0;
                  carry_q <= wr_sub;
               end
            end
            S_ADD: begin
               s1_q    <= add_s;
               c1_q    <= add_co;
               state_q <= S_CARRY;
            end
            S_CARRY: begin
               r_q[{idx_q, 4'b0} +: 16] <= add_s;
               carry_q <= c1_q | add_co;
               if (idx_q == nl_q) begin
                  state_q <= S_DONE;
                  done_q  <= 1'b1;
               end else begin
                  idx_q   <= idx_q + 2'd1;
                  state_q <= S_ADD;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign wbs_ack_o = ack_q;
   assign wbs_dat_o = dat_q;
   assign irq_o     = done_q & irq_en_q;

endmodule

// File: tb/tb_ksa_wide_seq.sv
// Randomized self-checking bench for ksa_wide_seq against a plain-arithmetic model.
module tb_ksa_wide_seq;

   localparam logic [31:0] BASE = 32'h3000_0000;
`ifdef KSA_SEQ_SUB_EN
   localparam bit SUB_EN = 1'b1;
`else
   localparam bit SUB_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stb, cyc, we;
   logic [3:0]  sel;
   logic [31:0] adr, dat_w;
   logic        ack;
   logic [31:0] dat_r;
   logic        irq;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   ksa_wide_seq #(.LIMBS(4), .BASE_ADDR(BASE)) dut (
      .wb_clk_i  (clk),
      .wb_rst_ni (rst_n),
      .wbs_stb_i (stb),
      .wbs_cyc_i (cyc),
      .wbs_we_i  (we),
      .wbs_sel_i (sel),
      .wbs_adr_i (adr),
      .wbs_dat_i (dat_w),
      .wbs_ack_o (ack),
      .wbs_dat_o (dat_r),
      .irq_o     (irq)
   );

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Model: result and carry out of an n-limb add or A-B.
   function automatic logic [64:0] model(input int n, input logic [63:0] a,
                                         input logic [63:0] b, input bit sub);
      logic [64:0] m, s, bb;
      m  = (65'd1 << (16 * n)) - 65'd1;
      bb = sub ? ~{1'b0, b} : {1'b0, b};
      s  = ({1'b0, a} & m) + (bb & m) + {64'd0, sub};
      return {s[16*n], s[63:0] & m[63:0]};
   endfunction

   task automatic xfer(input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s,
                       output logic [31:0] rd, output int lat);
      stb = 1'b1; cyc = 1'b1; we = w; adr = a; dat_w = d; sel = s;
      lat = 0;
      rd  = '0;
      do begin
         @(posedge clk); #1;
         lat++;
      end while (!ack && lat < 8);
      if (ack) begin
         rd = dat_r;
         @(posedge clk); #1;
      end else begin
         lat = -1;
      end
      stb = 1'b0; cyc = 1'b0; we = 1'b0;
   endtask

   task automatic wr32(input logic [7:0] off, input logic [31:0] d);
      logic [31:0] rd;
      int lat;
      xfer(1'b1, BASE | {24'd0, off}, d, 4'hF, rd, lat);
      check("wr_ack_lat", lat, 1);
   endtask

   task automatic rd32(input logic [7:0] off, output logic [31:0] d);
      int lat;
      xfer(1'b0, BASE | {24'd0, off}, 32'd0, 4'hF, d, lat);
      check("rd_ack_lat", lat, 1);
   endtask

   // Load operands and start; c counts edges since the start ack edge.
   task automatic start_op(input int n, input logic [63:0] a,
                           input logic [63:0] b, input bit sub,
                           input bit ie, output int c);
      wr32(8'h08, a[31:0]);
      wr32(8'h0C, a[63:32]);
      wr32(8'h10, b[31:0]);
      wr32(8'h14, b[63:32]);
      wr32(8'h00, (32'(ie) << 8) | (32'(sub) << 3) | (32'(n - 1) << 1) | 32'd1);
      c = 1;
   endtask

   task automatic wait_irq(input int c0, output int c);
      c = c0;
      while (!irq && c < 60) begin
         @(posedge clk); #1;
         c++;
      end
   endtask

   task automatic check_result(input string tag, input int n,
                               input logic [63:0] a, input logic [63:0] b,
                               input bit sub);
      logic [64:0] e;
      logic [31:0] lo, hi, st;
      e = model(n, a, b, sub & SUB_EN);
      rd32(8'h18, lo);
      rd32(8'h1C, hi);
      rd32(8'h04, st);
      check({tag, "_R"}, {hi, lo}, e[63:0]);
      check({tag, "_status"}, {32'd0, st}, {61'd0, e[64], 2'b10});
   endtask

   initial begin
      logic [63:0] a, b;
      logic [31:0] rd;
      int c, lat, n, seen;
      bit sub;

      rst_n = 1'b0; stb = 1'b0; cyc = 1'b0; we = 1'b0;
      sel = '0; adr = '0; dat_w = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ack", {63'd0, ack}, 0);
      check("rst_dat", {32'd0, dat_r}, 0);
      check("rst_irq", {63'd0, irq}, 0);
      rst_n = 1'b1;
      rd32(8'h04, rd);
      check("rst_status", {32'd0, rd}, 0);

      // Byte-lane merge on operand writes.
      wr32(8'h08, 32'hFFFF_FFFF);
      xfer(1'b1, BASE | 32'h08, 32'h1234_5678, 4'b0101, rd, lat);
      rd32(8'h08, rd);
      check("sel_merge", {32'd0, rd}, 64'hFF34_FF78);

      // Full carry ripple across all four limbs.
      start_op(4, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b1, c);
      wait_irq(c, c);
      check("ripple_cycles", c, 9);
      check_result("ripple", 4, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);

      // Single limb: upper limbs of R stay zero.
      start_op(1, 64'h0000_0000_0000_1234, 64'd1, 1'b0, 1'b1, c);
      wait_irq(c, c);
      check("n1_cycles", c, 3);
      check_result("n1", 1, 64'h1234, 64'd1, 1'b0);

      start_op(2, 64'd5, 64'd7, 1'b1, 1'b1, c);
      wait_irq(c, c);
      check("sub57_cycles", c, 5);
      check_result("sub57", 2, 64'd5, 64'd7, 1'b1);
      rd32(8'h00, rd);
      check("ctrl_rb", {32'd0, rd}, {55'd0, 1'b1, 4'd0, SUB_EN, 2'd1, 1'b0});
      start_op(2, 64'd7, 64'd5, 1'b1, 1'b1, c);
      wait_irq(c, c);
      check_result("sub75", 2, 64'd7, 64'd5, 1'b1);

      for (int k = 0; k < 24; k++) begin
         n   = $urandom_range(1, 4);
         a   = {$urandom, $urandom};
         b   = {$urandom, $urandom};
         sub = 1'($urandom_range(0, 1));
         if (k % 3 == 0) b = ~a ^ 64'($urandom_range(0, 1));
         start_op(n, a, b, sub, 1'b1, c);
         wait_irq(c, c);
         check("rand_cycles", c, 1 + 2 * n);
         check_result("rand", n, a, b, sub);
      end

      // Writes and a second start while busy are ignored.
      a = 64'h0123_4567_89AB_CDEF;
      b = 64'hFEDC_BA98_7654_3210;
      start_op(4, a, b, 1'b0, 1'b1, c);
      wr32(8'h08, 32'd0);
      wr32(8'h00, 32'h0000_0001);
      c += 4;
      wait_irq(c, c);
      check("busy_cycles", c, 9);
      check_result("busy", 4, a, b, 1'b0);
      rd32(8'h00, rd);
      check("busy_ctrl", {32'd0, rd}, 64'h0000_0106);

      // W1C done drops irq; nothing restarts afterwards.
      wr32(8'h04, 32'h2);
      check("w1c_irq", {63'd0, irq}, 0);
      seen = 0;
      repeat (20) begin
         @(posedge clk); #1;
         if (irq) seen = 1;
      end
      check("no_rerun", seen, 0);
      rd32(8'h04, rd);
      check("w1c_status", {32'd0, rd}, {61'd0, model(4, a, b, 1'b0) >> 64, 2'b00});

      // Reset during limb 2 aborts.
      start_op(4, a, b, 1'b0, 1'b1, c);
      repeat (4) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      seen = 0;
      repeat (20) begin
         @(posedge clk); #1;
         if (irq) seen = 1;
      end
      check("rst_mid_irq", seen, 0);
      rd32(8'h04, rd);
      check("rst_mid_status", {32'd0, rd}, 0);
      rd32(8'h18, rd);
      check("rst_mid_r", {32'd0, rd}, 0);

      // Unmapped offset in window and out-of-window access.
      xfer(1'b0, BASE | 32'h20, 32'd0, 4'hF, rd, lat);
      check("unmapped_lat", lat, 1);
      check("unmapped_dat", {32'd0, rd}, 0);
      xfer(1'b1, BASE | 32'h20, 32'hDEAD_BEEF, 4'hF, rd, lat);
      check("unmapped_wlat", lat, 1);
      xfer(1'b0, BASE + 32'h100, 32'd0, 4'hF, rd, lat);
      check("oow_noack", lat, -1);
      check("idle_dat", {32'd0, dat_r}, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
